// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences fetch, decode,
// execute, memory and write-back over a shared memory port, with timeout and retire count.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             br_ltu,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_src,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_src,
  output logic             alu_src1,
  output logic             alu_src2,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_BR, C_JAL, C_JALR, C_LW, C_SW
  } cls_t;

  state_t        cur, nxt;
  logic [TW-1:0] tcnt;
  logic [1:0]    err_q;
  logic [CNT_W-1:0] cnt_q;

  cls_t       dec_cls, cls_p1;
  logic [2:0] dec_op, op_p1;
  logic       dec_s1, dec_s2, s1_p1, s2_p1;
  logic [1:0] dec_br, br_p1;
  logic       dec_ill;

  logic       ill_hit, to_hit, retire_nxt_run, taken, tmo;

  // Instruction classification; lui/auipc ride the ALU path with imm on port 2
  always_comb begin
    dec_cls = C_ALU;
    dec_op  = 3'b001;
    dec_s1  = 1'b0;
    dec_s2  = 1'b1;
    dec_br  = 2'd0;
    dec_ill = 1'b0;
    case (instr[6:0])
      7'b0010011: begin
        case (instr[14:12])
          3'b000:  dec_op = 3'b001;
          3'b001:  dec_op = 3'b110;
          3'b101:  dec_op = instr[30] ? 3'b111 : 3'b101;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0110011: begin
        dec_s2 = 1'b0;
        case (instr[14:12])
          3'b000:  dec_op = instr[30] ? 3'b000 : 3'b001;
          3'b100:  dec_op = 3'b100;
          3'b110:  dec_op = 3'b011;
          3'b111:  dec_op = 3'b010;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0110111: dec_cls = C_ALU;
      7'b0010111: dec_s1 = 1'b1;
      7'b1101111: begin
        dec_cls = C_JAL;
        dec_s1  = 1'b1;
      end
      7'b1100111: begin
        dec_cls = C_JALR;
        dec_ill = (instr[14:12] != 3'b000);
      end
      7'b1100011: begin
        dec_cls = C_BR;
        dec_s2  = 1'b0;
        dec_op  = 3'b000;
        case (instr[14:12])
          3'b000:  dec_br = 2'd0;
          3'b100:  dec_br = 2'd1;
          3'b110:  dec_br = 2'd2;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_cls = C_LW;
        dec_ill = (instr[14:12] != 3'b010);
      end
      7'b0100011: begin
        dec_cls = C_SW;
        dec_ill = (instr[14:12] != 3'b010);
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign taken = (br_p1 == 2'd0 && br_eq) || (br_p1 == 2'd1 && br_lt) ||
                 (br_p1 == 2'd2 && br_ltu);
  assign tmo = (tcnt == TW'(TIMEOUT - 1));
  assign retire_nxt_run = run;

  // Outputs are forced quiet while reset is asserted so an abandoned
  // instruction can never emit a write pulse on its way out.
  always_comb begin
    nxt          = cur;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    reg_we       = 1'b0;
    wb_src       = 2'b00;
    alu_src1     = 1'b0;
    alu_src2     = 1'b0;
    alu_op       = 3'b000;
    ill_hit      = 1'b0;
    to_hit       = 1'b0;
    if (rstn) begin
      case (cur)
        S_IDLE: if (run) nxt = S_FETCH;
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we = 1'b1;
            nxt   = S_DECODE;
          end else if (tmo) begin
            to_hit = 1'b1;
            nxt    = S_HALT;
          end
        end
        S_DECODE: begin
          if (dec_ill) begin
            ill_hit = 1'b1;
            nxt     = S_HALT;
          end else begin
            nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_src1 = s1_p1;
          alu_src2 = s2_p1;
          alu_op   = op_p1;
          case (cls_p1)
            C_ALU:  nxt = S_WB;
            C_BR: begin
              pc_we  = 1'b1;
              pc_src = taken ? 2'b01 : 2'b00;
            end
            C_JAL: begin
              reg_we = 1'b1;
              wb_src = 2'b10;
              pc_we  = 1'b1;
              pc_src = 2'b01;
            end
            C_JALR: begin
              reg_we = 1'b1;
              wb_src = 2'b10;
              pc_we  = 1'b1;
              pc_src = 2'b10;
            end
            default: nxt = S_MEM;
          endcase
        end
        S_MEM: begin
          alu_src1     = s1_p1;
          alu_src2     = s2_p1;
          alu_op       = op_p1;
          mem_req      = 1'b1;
          mem_addr_src = 1'b1;
          mem_we       = (cls_p1 == C_SW);
          if (mem_ack) begin
            if (cls_p1 == C_SW) pc_we = 1'b1;
            else nxt = S_WB;
          end else if (tmo) begin
            to_hit = 1'b1;
            nxt    = S_HALT;
          end
        end
        S_WB: begin
          alu_src1 = s1_p1;
          alu_src2 = s2_p1;
          alu_op   = op_p1;
          reg_we   = 1'b1;
          wb_src   = (cls_p1 == C_LW) ? 2'b01 : 2'b00;
          pc_we    = 1'b1;
        end
        S_HALT:  nxt = S_HALT;
        default: nxt = S_IDLE;
      endcase
      if (pc_we) nxt = retire_nxt_run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur    <= S_IDLE;
      tcnt   <= '0;
      err_q  <= 2'b00;
      cnt_q  <= '0;
      cls_p1 <= C_ALU;
      op_p1  <= 3'b000;
      s1_p1  <= 1'b0;
      s2_p1  <= 1'b0;
      br_p1  <= 2'd0;
    end else begin
      cur <= nxt;
      if (!mem_req || mem_ack || nxt != cur) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
      if (to_hit) err_q <= 2'b10;
      else if (ill_hit) err_q <= 2'b01;
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
      if (cur == S_DECODE) begin
        cls_p1 <= dec_cls;
        op_p1  <= dec_op;
        s1_p1  <= dec_s1;
        s2_p1  <= dec_s2;
        br_p1  <= dec_br;
      end
    end
  end

  assign state    = cur;
  assign halted   = (cur == S_HALT);
  assign err_code = err_q;
  assign instret  = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset core. It replaces single-cycle control with an FSM that drives the shared PC, IR, ALU, register file and a single unified memory port over several cycles per instruction.
- Decodes the same instruction subset as the core's decoder: addi, slli, srli, srai, add, sub, xor, or, and, lui, auipc, jal, jalr, beq, blt, bltu, lw, sw.
- Handles a variable-latency memory req/ack handshake, an ack timeout, illegal-instruction halt, and a retired-instruction counter.

Parameters:
- TIMEOUT, 16: maximum cycles mem_req may stay high without mem_ack before bus error.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rstn  in  1  reset, synchronous, active-low.
- run  in  1  level; permits starting a new instruction.
- instr  in  32  current IR contents (valid from DECODE onward).
- br_eq  in  1  rs1==rs2 from the comparator.
- br_lt  in  1  signed rs1<rs2.
- br_ltu  in  1  unsigned rs1<rs2.
- mem_ack  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier; valid only with mem_req.
- mem_addr_src  out  1  0=PC, 1=ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  2  00=PC+4, 01=PC+imm, 10=ALU result & ~1.
- reg_we  out  1  register-file write.
- wb_src  out  2  00=ALU, 01=memory data register, 10=PC+4.
- alu_src1  out  1  0=rs1, 1=PC.
- alu_src2  out  1  0=rs2, 1=imm.
- alu_op  out  3  000 sub, 001 add, 010 and, 011 or, 100 xor, 101 srl, 110 sll, 111 sra.
- halted  out  1  sticky; FSM is in HALT.
- err_code  out  2  00 none, 01 illegal instruction, 10 bus timeout.
- state  out  3  current state, for debug.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7.
- Reset (rstn=0 at a clk edge): state=IDLE, instret=0, err_code=00, halted=0, timeout counter cleared.
  - Reset applies mid-instruction and mid-request: the request is abandoned, no pc_we or reg_we pulse.
- All outputs are combinational from state and latched decode. Every output is 0 in IDLE, DECODE and HALT.

State transitions:
- IDLE: if run, go to FETCH next cycle; otherwise stay.
- FETCH: mem_req=1, mem_addr_src=0, mem_we=0.
  - On mem_ack: ir_we=1 in the same cycle, go to DECODE.
- DECODE (1 cycle): classify instr and register the class, alu_op and branch type.
  - Unsupported opcode/funct3: go to HALT, err_code=01.
  - srli vs srai is selected by funct7[5]; add vs sub likewise.
- EXEC, by class:
  - ALU-R/ALU-I/lui/auipc: drive alu_src1/alu_src2/alu_op; go to WB.
  - Branch: pc_we=1, pc_src=01 if (beq&br_eq | blt&br_lt | bltu&br_ltu), else 00; retire; go to FETCH.
  - jal: reg_we=1, wb_src=10, pc_we=1, pc_src=01; retire; go to FETCH.
  - jalr: alu_src1=0, alu_src2=1, alu_op=001; reg_we=1, wb_src=10, pc_we=1, pc_src=10; retire; go to FETCH.
  - lw/sw: alu add with imm; go to MEM.
- MEM: mem_req=1, mem_addr_src=1, mem_we=1 for sw; ALU controls are held.
  - On ack, sw: pc_we=1, pc_src=00; retire; go to FETCH.
  - On ack, lw: go to WB.
- WB: reg_we=1 (wb_src=01 for lw, else 00), pc_we=1, pc_src=00; retire; go to FETCH.
- FETCH is entered from a retiring state only if run=1; otherwise IDLE. An in-flight instruction always completes regardless of run.
- HALT: absorbing until reset; halted=1.

Counters and timeout:
- Retire means pc_we asserted. instret increments by exactly 1 on that cycle and wraps modulo 2^CNT_W.
- Timeout counter counts consecutive mem_req cycles without mem_ack and clears on ack or state change.
  - Reaching TIMEOUT without ack: go to HALT, err_code=10, no ir_we/pc_we/reg_we.
  - An ack on the TIMEOUT-th cycle counts as success.
- mem_ack outside FETCH/MEM is ignored.
- Latency with ack in the first request cycle: ALU ops 4 cycles, branch/jal/jalr 3, sw 4, lw 5.

Test Plan:
- Reset then run=1, instr=0x00500093 (addi x1,x0,5), ack immediate → states 1,2,3,5,1; WB has reg_we=1, wb_src=00, alu_op=001, alu_src2=1; instret=1.
- instr=0x402081B3 (sub) → alu_op=000, alu_src2=0; 0x4050D093 (srai) → alu_op=111.
- instr=0x00000463 (beq) with br_eq=1 → EXEC pc_we=1, pc_src=01. With br_eq=0 → pc_src=00. 3 cycles each, reg_we never set.
- instr=0x00002283 (lw), ack delayed 3 cycles in MEM → mem_req high 4 cycles with addr_src=1; WB wb_src=01; instret +1.
- Memory never acks in FETCH, TIMEOUT=16 → after 16 request cycles state=7, err_code=10, no ir_we. instr=0x00000000 → HALT, err_code=01. Only rstn=0 recovers.
- run dropped during lw, then rstn=0 asserted mid-MEM in a second run → first lw retires then IDLE; after reset state=0, instret=0, no write pulses.
